// File: rtl/deadlock_wdog_ctrl.sv
// deadlock_wdog_ctrl: watches a set of dataflow processes for a global stall.
// A stall is one where at least one process waits on an AXIS port and every
// other process is either idle or waiting on a channel.
// When the stall persists for the threshold number of cycles, the block trips,
// raises a sticky block flag, and emits one snapshot report.
// Optional build macro: DEADLOCK_WDOG_STAMP_EN adds a free-running cycle
// timestamp to the report. Without it, rpt_stamp is tied to zero.
module deadlock_wdog_ctrl #(
    parameter int NPROC = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] threshold,
    input  logic [NPROC-1:0] proc_idle,
    input  logic [NPROC-1:0] proc_chan_block,
    input  logic [NPROC-1:0] proc_axis_block,
    input  logic             clear,
    output logic             block,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [NPROC-1:0] rpt_axis_vec,
    output logic [NPROC-1:0] rpt_chan_vec,
    output logic [31:0]      rpt_stamp,
    output logic [7:0]       trip_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        COUNT   = 2'd2,
        TRIPPED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             stall;
    logic             trip;
    logic             release_trip;
    logic [CNT_W-1:0] eff_threshold;
    logic [CNT_W-1:0] trip_level;

    // A stall needs some AXIS wait, and no process may be doing useful work.
    assign stall         = (|proc_axis_block) &
                           (&(proc_idle | proc_chan_block | proc_axis_block));
    // A zero threshold behaves like one, so the block can never trip
    // without a stall.
    assign eff_threshold = (threshold == '0) ? CNT_ONE : threshold;
    assign trip_level    = eff_threshold - CNT_ONE;
    assign release_trip  = enable && (state == TRIPPED) && clear;

    // Next-state and stall-counter logic. Enable low overrides everything else.
    always_comb begin
        state_next = state;
        count_next = count;
        trip       = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = WATCH;
                    count_next = '0;
                end
                WATCH: begin
                    count_next = '0;
                    if (!clear && stall) begin
                        if (eff_threshold == CNT_ONE) begin
                            state_next = TRIPPED;
                            trip       = 1'b1;
                        end else begin
                            state_next = COUNT;
                            count_next = CNT_ONE;
                        end
                    end
                end
                COUNT: begin
                    if (clear || !stall) begin
                        state_next = WATCH;
                        count_next = '0;
                    end else if (count >= trip_level) begin
                        state_next = TRIPPED;
                        count_next = '0;
                        trip       = 1'b1;
                    end else if (count != CNT_MAX) begin
                        count_next = count + CNT_ONE;
                    end
                end
                TRIPPED: begin
                    count_next = '0;
                    if (clear) begin
                        state_next = WATCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // State, counter and the registered deadlock flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            block <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            block <= (state_next == TRIPPED);
        end
    end

    // Report handshake, payload capture and the saturating trip counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_valid    <= 1'b0;
            rpt_axis_vec <= '0;
            rpt_chan_vec <= '0;
            trip_count   <= 8'd0;
        end else begin
            if (trip) begin
                rpt_valid    <= 1'b1;
                rpt_axis_vec <= proc_axis_block;
                rpt_chan_vec <= proc_chan_block;
                if (trip_count != 8'hFF) begin
                    trip_count <= trip_count + 8'd1;
                end
            end else if ((rpt_valid && rpt_ready) || release_trip) begin
                rpt_valid <= 1'b0;
            end
        end
    end

`ifdef DEADLOCK_WDOG_STAMP_EN
    logic [31:0] stamp_cnt;

    // Free-running wrapping cycle counter, and the capture of its value on a trip.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stamp_cnt <= 32'd0;
            rpt_stamp <= 32'd0;
        end else begin
            stamp_cnt <= stamp_cnt + 32'd1;
            if (trip) begin
                rpt_stamp <= stamp_cnt;
            end
        end
    end
`else
    assign rpt_stamp = 32'd0;
`endif

endmodule

// File: tb/tb_deadlock_wdog_ctrl.sv
// tb_deadlock_wdog_ctrl: directed bench for deadlock_wdog_ctrl.
// A behavioural model tracks the stall run length, the trip status and the
// report state. The outputs are compared against the model on every falling
// edge. Hand-computed literal checks pin the model at key points.
module tb_deadlock_wdog_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] threshold = 16'd0;
    logic [3:0]  proc_idle = 4'd0;
    logic [3:0]  proc_chan_block = 4'd0;
    logic [3:0]  proc_axis_block = 4'd0;
    logic        clear = 1'b0;
    logic        rpt_ready = 1'b0;
    logic        block;
    logic        rpt_valid;
    logic [3:0]  rpt_axis_vec;
    logic [3:0]  rpt_chan_vec;
    logic [31:0] rpt_stamp;
    logic [7:0]  trip_count;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          m_armed = 1'b0;
    bit          m_tripped = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_do_trip = 1'b0;
    int          m_run = 0;
    int          m_eff = 1;
    int          m_trips = 0;
    logic [3:0]  m_axis = 4'd0;
    logic [3:0]  m_chan = 4'd0;
    logic [31:0] m_stamp = 32'd0;
    logic [31:0] m_cycles = 32'd0;

    deadlock_wdog_ctrl #(.NPROC(4), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .threshold(threshold),
        .proc_idle(proc_idle),
        .proc_chan_block(proc_chan_block),
        .proc_axis_block(proc_axis_block),
        .clear(clear),
        .block(block),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_axis_vec(rpt_axis_vec),
        .rpt_chan_vec(rpt_chan_vec),
        .rpt_stamp(rpt_stamp),
        .trip_count(trip_count)
    );

    // Free-running 10-time-unit clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the inputs at the current falling edge and hold them for n rising edges.
    task automatic applyStimulus(input logic en, input logic [15:0] thr,
                                 input logic [3:0] idle, input logic [3:0] chan,
                                 input logic [3:0] axis, input logic clr,
                                 input logic rdy, input int n);
        enable          = en;
        threshold       = thr;
        proc_idle       = idle;
        proc_chan_block = chan;
        proc_axis_block = axis;
        clear           = clr;
        rpt_ready       = rdy;
        repeat (n) @(negedge clock);
    endtask

    function automatic bit modelStall();
        bit any_axis = 1'b0;
        bit all_parked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (proc_axis_block[i]) any_axis = 1'b1;
            if (!(proc_idle[i] || proc_chan_block[i] || proc_axis_block[i])) all_parked = 1'b0;
        end
        return any_axis && all_parked;
    endfunction

    // Behavioural model. It counts consecutive stall cycles while armed and
    // trips when the count reaches the effective threshold.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_armed = 0; m_tripped = 0; m_valid = 0; m_run = 0; m_trips = 0;
                m_axis = 0; m_chan = 0; m_stamp = 0; m_cycles = 0;
            end else begin
                m_do_trip = 1'b0;
                m_eff = (threshold == 16'd0) ? 1 : int'(threshold);
                if (m_valid && rpt_ready) m_valid = 1'b0;
                if (!enable) begin
                    m_armed = 0; m_run = 0; m_tripped = 0;
                end else if (!m_armed) begin
                    m_armed = 1;
                end else if (m_tripped) begin
                    if (clear) begin
                        m_tripped = 0; m_valid = 0; m_run = 0;
                    end
                end else if (clear || !modelStall()) begin
                    m_run = 0;
                end else begin
                    m_run = m_run + 1;
                    if (m_run >= m_eff) m_do_trip = 1'b1;
                end
                if (m_do_trip) begin
                    m_tripped = 1; m_valid = 1; m_run = 0;
                    m_axis = proc_axis_block;
                    m_chan = proc_chan_block;
                    if (m_trips < 255) m_trips = m_trips + 1;
`ifdef DEADLOCK_WDOG_STAMP_EN
                    m_stamp = m_cycles;
`else
                    m_stamp = 32'd0;
`endif
                end
                m_cycles = m_cycles + 32'd1;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            checkOutput("block", {31'd0, block}, {31'd0, m_tripped});
            checkOutput("rpt_valid", {31'd0, rpt_valid}, {31'd0, m_valid});
            checkOutput("rpt_axis_vec", {28'd0, rpt_axis_vec}, {28'd0, m_axis});
            checkOutput("rpt_chan_vec", {28'd0, rpt_chan_vec}, {28'd0, m_chan});
            checkOutput("rpt_stamp", rpt_stamp, m_stamp);
            checkOutput("trip_count", {24'd0, trip_count}, 32'(m_trips));
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [31:0] stamp_exp;
        @(negedge clock);
        checkOutput("reset_block", {31'd0, block}, 32'd0);
        checkOutput("reset_trip_count", {24'd0, trip_count}, 32'd0);
        reset = 1'b0;

        // Arm with threshold 4, then stall four cycles to trip on the fourth edge.
        applyStimulus(1, 16'd4, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2);
        applyStimulus(1, 16'd4, 4'b0000, 4'b1100, 4'b0011, 0, 0, 3);
        checkOutput("thr4_no_trip_at_3", {31'd0, block}, 32'd0);
        applyStimulus(1, 16'd4, 4'b0000, 4'b1100, 4'b0011, 0, 0, 1);
        checkOutput("thr4_block", {31'd0, block}, 32'd1);
        checkOutput("thr4_valid", {31'd0, rpt_valid}, 32'd1);
        checkOutput("thr4_trip_count", {24'd0, trip_count}, 32'd1);
        checkOutput("thr4_axis_vec", {28'd0, rpt_axis_vec}, 32'h3);

        // Hold the report for five cycles with ready low, then accept it.
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 0, 0, 5);
        checkOutput("hold_valid", {31'd0, rpt_valid}, 32'd1);
        checkOutput("hold_chan_vec", {28'd0, rpt_chan_vec}, 32'hC);
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 0, 1, 1);
        checkOutput("ready_drops_valid", {31'd0, rpt_valid}, 32'd0);
        checkOutput("ready_keeps_block", {31'd0, block}, 32'd1);
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);
        checkOutput("clear_block", {31'd0, block}, 32'd0);

        // Three stall cycles, a one-cycle gap, then three more never reach 4.
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 0, 0, 3);
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1);
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 0, 0, 3);
        checkOutput("gap_no_trip", {31'd0, block}, 32'd0);
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1);

        // A zero threshold trips after a single stall cycle.
        applyStimulus(1, 16'd0, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
        checkOutput("thr0_block", {31'd0, block}, 32'd1);
        checkOutput("thr0_axis_vec", {28'd0, rpt_axis_vec}, 32'h1);
        checkOutput("thr0_chan_vec", {28'd0, rpt_chan_vec}, 32'h0);
        checkOutput("thr0_trip_count", {24'd0, trip_count}, 32'd2);
        applyStimulus(1, 16'd0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 1);
        checkOutput("clear_ready_valid", {31'd0, rpt_valid}, 32'd0);
        checkOutput("clear_ready_block", {31'd0, block}, 32'd0);

        // Lowering the threshold below the current run trips on the next stall.
        applyStimulus(1, 16'd10, 4'b1110, 4'b0000, 4'b0001, 0, 0, 5);
        applyStimulus(1, 16'd3, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
        checkOutput("lowered_thr_trip", {31'd0, block}, 32'd1);
        applyStimulus(1, 16'd3, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);

        // One process stays busy, so this pattern is not a stall.
        applyStimulus(1, 16'd1, 4'b0000, 4'b0110, 4'b0001, 0, 0, 3);
        checkOutput("busy_proc_no_trip", {31'd0, block}, 32'd0);

        // Enable low during counting aborts the count.
        applyStimulus(1, 16'd5, 4'b1110, 4'b0000, 4'b0001, 0, 0, 3);
        applyStimulus(0, 16'd5, 4'b1110, 4'b0000, 4'b0001, 0, 0, 3);
        checkOutput("disable_no_trip", {31'd0, block}, 32'd0);
        applyStimulus(1, 16'd5, 4'b1110, 4'b0000, 4'b0001, 0, 0, 2);
        checkOutput("reenable_restart", {31'd0, block}, 32'd0);
        applyStimulus(1, 16'd5, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1);

        // A clear while counting restarts the run.
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 0, 0, 2);
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 1, 0, 1);
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 0, 0, 3);
        checkOutput("count_clear_no_trip", {31'd0, block}, 32'd0);
        applyStimulus(1, 16'd4, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
        checkOutput("count_clear_then_trip", {31'd0, block}, 32'd1);
        applyStimulus(1, 16'd4, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);

        // Repeated trip/clear pairs saturate the trip counter.
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1, 16'd1, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
            applyStimulus(1, 16'd1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1);
        end
        checkOutput("trip_count_saturated", {24'd0, trip_count}, 32'd255);

        // Reset asserted mid-cycle while tripped clears all outputs at once.
        applyStimulus(1, 16'd1, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
        checkOutput("pre_reset_block", {31'd0, block}, 32'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_block", {31'd0, block}, 32'd0);
        checkOutput("async_reset_valid", {31'd0, rpt_valid}, 32'd0);
        checkOutput("async_reset_axis", {28'd0, rpt_axis_vec}, 32'd0);
        checkOutput("async_reset_trip_count", {24'd0, trip_count}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // A trip on the 101st edge after reset release stamps the value 100.
        applyStimulus(1, 16'd1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 100);
        applyStimulus(1, 16'd1, 4'b1110, 4'b0000, 4'b0001, 0, 0, 1);
`ifdef DEADLOCK_WDOG_STAMP_EN
        stamp_exp = 32'd100;
`else
        stamp_exp = 32'd0;
`endif
        checkOutput("stamp_value", rpt_stamp, stamp_exp);
        checkOutput("stamp_trip_count", {24'd0, trip_count}, 32'd1);
        applyStimulus(1, 16'd1, 4'b1111, 4'b0000, 4'b0000, 1, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deadlock_wdog_ctrl.md
DEADLOCK_WDOG_CTRL -- requirements
Module: deadlock_wdog_ctrl

Interface
REQ-001 Parameter NPROC, default 4: number of dataflow processes watched.
REQ-002 Parameter CNT_W, default 16: width of the stall threshold and stall counter.
REQ-003 clock  input  1  single clock for all state; rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  watchdog enable; low forces IDLE.
REQ-006 threshold  input  CNT_W  consecutive stall cycles required to trip; 0 treated as 1.
REQ-007 proc_idle  input  NPROC  per-process idle.
REQ-008 proc_chan_block  input  NPROC  per-process blocked on an internal FIFO channel.
REQ-009 proc_axis_block  input  NPROC  per-process blocked on an AXIS port.
REQ-010 clear  input  1  single-cycle request to release a trip and re-arm.
REQ-011 block  output  1  registered deadlock flag.
REQ-012 rpt_valid  output  1  snapshot report valid.
REQ-013 rpt_ready  input  1  report consumer ready.
REQ-014 rpt_axis_vec  output  NPROC  proc_axis_block captured on trip.
REQ-015 rpt_chan_vec  output  NPROC  proc_chan_block captured on trip.
REQ-016 rpt_stamp  output  32  cycle timestamp of the trip (see Configuration).
REQ-017 trip_count  output  8  number of trips since reset, saturating at 255.

Function
REQ-018 stall = (OR of proc_axis_block) AND (for every i: proc_idle[i] OR proc_chan_block[i] OR proc_axis_block[i]), evaluated combinationally each cycle.
REQ-019 FSM states: IDLE, WATCH, COUNT, TRIPPED; enable low in any state moves to IDLE on the next edge, taking priority over clear and stall.
REQ-020 IDLE -> WATCH when enable=1; stall counter is held at 0 in IDLE and WATCH.
REQ-021 WATCH -> COUNT when stall=1, with counter loaded to 1 on the same edge.
REQ-022 In COUNT, stall=1 increments the counter (saturating at 2^CNT_W-1); stall=0 returns to WATCH with counter cleared.
REQ-023 COUNT -> TRIPPED on the edge where stall=1 and the counter value before that edge is >= effective threshold-1; that is, trip when stall has held for effective-threshold consecutive cycles. When the effective threshold is 1, WATCH -> TRIPPED on the first stall cycle, bypassing COUNT.
REQ-024 On entry to TRIPPED: block=1, rpt_valid=1, rpt_axis_vec/rpt_chan_vec/rpt_stamp are captured from that cycle's inputs, and trip_count increments.
REQ-025 rpt_valid stays high, with stable payload, until sampled with rpt_ready=1; it then drops on the next edge and is not reasserted until a new trip.
REQ-026 TRIPPED persists regardless of stall until clear=1, then -> WATCH with block=0, counter=0, and rpt_valid=0 (a pending report is discarded).
REQ-027 clear in WATCH or COUNT clears the counter and goes to or stays in WATCH; clear in IDLE has no effect.
REQ-028 Simultaneous clear and rpt_ready in TRIPPED: the handshake completes and the FSM moves to WATCH.
REQ-029 Changes to threshold take effect on the next COUNT comparison; a lowered threshold already exceeded trips on the next stall cycle.

Reset
REQ-030 Reset asynchronously forces: state=IDLE, counter=0, block=0, rpt_valid=0, rpt_axis_vec=0, rpt_chan_vec=0, rpt_stamp=0, trip_count=0, and timestamp counter=0.
REQ-031 Reset asserted mid-COUNT or mid-TRIPPED aborts immediately, and no report is produced.

Configuration
REQ-032 With macro DEADLOCK_WDOG_STAMP_EN defined, a free-running 32-bit cycle counter (wrapping) runs from reset release, and rpt_stamp captures it on trip.
REQ-033 Without DEADLOCK_WDOG_STAMP_EN, no timestamp counter exists and rpt_stamp is constant 0.

Verification
REQ-034 threshold=4, stall held 4 cycles from WATCH -> block=1 and rpt_valid=1 on the 4th edge; trip_count=1.
REQ-035 threshold=4, stall held 3 cycles, 1 gap, then 3 cycles -> no trip; counter returns to 0 in the gap.
REQ-036 threshold=0, NPROC=4, axis=0001, idle=1110 for 1 cycle -> trip after one edge; rpt_axis_vec=0001, rpt_chan_vec=0000.
REQ-037 Trip with rpt_ready=0 for 5 cycles, then 1 -> payload stable for all 5 cycles, rpt_valid drops one edge after ready; block stays 1 until clear.
REQ-038 256 trip/clear cycles -> trip_count saturates at 255; enable=0 during COUNT -> IDLE, and no trip occurs.
REQ-039 Stamp-enabled build: trip 100 cycles after reset release -> rpt_stamp=100 (disabled build: 0); reset mid-TRIPPED -> all outputs 0 asynchronously.
